video_timing_pattern: RTL and testbench

VIDEO_TIMING_PATTERN -- requirements
Module: video_timing_pattern

---
 rtl/video_timing_pattern.sv | 173 +++++++++++++++++
 tb/tb_video_timing_pattern.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern.sv
// Video timing generator (sync/back porch/active/front porch) with built-in
// test patterns; every output except pix_req is registered one cycle after the counters.
module video_timing_pattern #(
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int H_ACT     = 1920,
    parameter int H_FP      = 88,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int V_ACT     = 1080,
    parameter int V_FP      = 4,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1,
    parameter int CW        = 12,
    parameter int GRID_LOG2 = 4
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [23:0]   ext_rgb,
    output logic          pix_req,
    output logic          h_sync,
    output logic          v_sync,
    output logic          pixel_de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic          line_start,
    output logic [7:0]    frame_cnt,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int BAR_W   = H_ACT / 8;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SE     = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SE     = CW'(V_SYNC);
    localparam logic [CW-1:0] H_AS     = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_AE     = CW'(H_SYNC + H_BP + H_ACT);
    localparam logic [CW-1:0] V_AS     = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_AE     = CW'(V_SYNC + V_BP + V_ACT);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_k_q, bar_k_d;
    logic [2:0]    mode_q, mode_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic          ls_q, ls_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic [23:0]   rgb_q, rgb_d;

    logic          act_pre;
    logic          at_origin;
    logic [CW-1:0] x_cur;
    logic [CW-1:0] y_cur;
    logic [23:0]   pat;

    always_comb begin
        act_pre   = (h_cnt_q >= H_AS) && (h_cnt_q < H_AE)
                 && (v_cnt_q >= V_AS) && (v_cnt_q < V_AE);
        pix_req   = act_pre & en;
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        x_cur     = h_cnt_q - H_AS;
        y_cur     = v_cnt_q - V_AS;

        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
                v_cnt_d = v_cnt_q;
            end
        end

        // Bar counters restart at every line start and while stopped.
        bar_px_d = bar_px_q;
        bar_k_d  = bar_k_q;
        if (!en || h_cnt_q == '0) begin
            bar_px_d = '0;
            bar_k_d  = '0;
        end else if (act_pre) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d = '0;
                if (bar_k_q != 3'd7)
                    bar_k_d = bar_k_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + CW'(1);
            end
        end

        mode_d = (en && at_origin) ? mode : mode_q;

        case (mode_q)
            3'd1:    pat = {3{x_cur[7:0]}};
            3'd2:    pat = {3{y_cur[7:0]}};
            3'd3:    pat = {{8{~bar_k_q[2]}}, {8{~bar_k_q[1]}}, {8{~bar_k_q[0]}}};
            3'd4:    pat = (x_cur[GRID_LOG2-1:0] == '0 || y_cur[GRID_LOG2-1:0] == '0)
                           ? 24'hFFFFFF : 24'h000000;
            3'd5:    pat = ext_rgb;
            default: pat = 24'h000000;
        endcase

        h_sync_d    = (en && h_cnt_q < H_SE) ? H_POL : ~H_POL;
        v_sync_d    = (en && v_cnt_q < V_SE) ? V_POL : ~V_POL;
        de_d        = pix_req;
        fs_d        = en && at_origin;
        ls_d        = en && (h_cnt_q == '0);
        pixel_x_d   = pix_req ? x_cur : '0;
        pixel_y_d   = pix_req ? y_cur : '0;
        rgb_d       = pix_req ? pat : 24'h000000;
        frame_cnt_d = frame_cnt_q + {7'd0, fs_d};
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            bar_px_q    <= '0;
            bar_k_q     <= '0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            h_sync_q    <= ~H_POL;
            v_sync_q    <= ~V_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
            pixel_x_q   <= '0;
            pixel_y_q   <= '0;
            rgb_q       <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            bar_px_q    <= bar_px_d;
            bar_k_q     <= bar_k_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            rgb_q       <= rgb_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign pixel_de    = de_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign frame_cnt   = frame_cnt_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];
endmodule

// File: tb/tb_video_timing_pattern.sv
// Directed bench for video_timing_pattern on a 24x10 toy raster.
// A second instance with active-low syncs covers the polarity parameters.
module tb_video_timing_pattern;
    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [2:0]  mode    = 3'd0;
    logic [23:0] ext_rgb = 24'h0;

    logic        pix_req, h_sync, v_sync, pixel_de, frame_start, line_start;
    logic [11:0] pixel_x, pixel_y;
    logic [7:0]  frame_cnt, r, g, b;

    logic        p_pix_req, p_h_sync, p_v_sync, p_de, p_fs, p_ls;
    logic [11:0] p_x, p_y;
    logic [7:0]  p_fc, p_r, p_g, p_b;

    int vectors = 0;
    int errs    = 0;

    typedef struct packed {
        logic        hs, vs, de, fs, ls;
        logic [11:0] x, y;
    } tim_t;

    video_timing_pattern #(
        .H_SYNC(2), .H_BP(3), .H_ACT(16), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACT(6), .V_FP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(12), .GRID_LOG2(2)
    ) u0 (
        .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .mode(mode),
        .ext_rgb(ext_rgb), .pix_req(pix_req), .h_sync(h_sync),
        .v_sync(v_sync), .pixel_de(pixel_de), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .frame_start(frame_start),
        .line_start(line_start), .frame_cnt(frame_cnt),
        .r(r), .g(g), .b(b)
    );

    video_timing_pattern #(
        .H_SYNC(2), .H_BP(3), .H_ACT(16), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACT(6), .V_FP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(12), .GRID_LOG2(2)
    ) u1 (
        .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .mode(mode),
        .ext_rgb(ext_rgb), .pix_req(p_pix_req), .h_sync(p_h_sync),
        .v_sync(p_v_sync), .pixel_de(p_de), .pixel_x(p_x),
        .pixel_y(p_y), .frame_start(p_fs), .line_start(p_ls),
        .frame_cnt(p_fc), .r(p_r), .g(p_g), .b(p_b)
    );

    always #5 vga_clk = ~vga_clk;

    // Expected registered outputs for the counter state n cycles after frame start.
    function automatic tim_t model(int n);
        tim_t m;
        int h, v;
        h    = n % 24;
        v    = (n / 24) % 10;
        m.hs = (h < 2);
        m.vs = (v < 1);
        m.de = (h >= 5) && (h < 21) && (v >= 3) && (v < 9);
        m.fs = (n % 240) == 0;
        m.ls = (h == 0);
        m.x  = m.de ? 12'(h - 5) : 12'd0;
        m.y  = m.de ? 12'(v - 3) : 12'd0;
        return m;
    endfunction

    function automatic tim_t obs();
        tim_t o;
        o.hs = h_sync;
        o.vs = v_sync;
        o.de = pixel_de;
        o.fs = frame_start;
        o.ls = line_start;
        o.x  = pixel_x;
        o.y  = pixel_y;
        return o;
    endfunction

    function automatic logic [23:0] bar_rgb(logic [11:0] x);
        logic [2:0] k;
        k = 3'(x / 2);
        return {{8{~k[2]}}, {8{~k[1]}}, {8{~k[0]}}};
    endfunction

    function automatic logic [23:0] seed(int t);
        return {8'(t), 8'(t ^ 8'h5A), 8'(255 - t)};
    endfunction

    task automatic do_reset(input logic [2:0] m);
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = m;
        @(negedge vga_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tim_t o;
        @(negedge vga_clk);
        o = obs();
        vectors++;
        if (o !== tim_t'(0)) begin
            errs++;
            $display("FAIL reset_state got %h want %h", o, tim_t'(0));
        end
        vectors++;
        if ({frame_cnt, r, g, b, pix_req} !== 33'h0) begin
            errs++;
            $display("FAIL reset_fc_rgb got %h want 0", {frame_cnt, r, g, b, pix_req});
        end
        vectors++;
        if ({p_h_sync, p_v_sync} !== 2'b11) begin
            errs++;
            $display("FAIL reset_pol got %b want 11", {p_h_sync, p_v_sync});
        end
    endtask

    task automatic test_timing();
        tim_t e, o, nx;
        int de_cnt = 0;
        logic [7:0] fce;
        do_reset(3'd0);
        for (int t = 0; t < 485; t++) begin
            @(negedge vga_clk);
            e   = model(t);
            nx  = model(t + 1);
            o   = obs();
            fce = 8'(t / 240 + 1);
            vectors++;
            if (o !== e) begin
                errs++;
                $display("FAIL timing t=%0d got %h want %h", t, o, e);
            end
            vectors++;
            if (frame_cnt !== fce) begin
                errs++;
                $display("FAIL frame_cnt t=%0d got %0d want %0d", t, frame_cnt, fce);
            end
            vectors++;
            if (pix_req !== nx.de) begin
                errs++;
                $display("FAIL pix_req t=%0d got %b want %b", t, pix_req, nx.de);
            end
            vectors++;
            if ({r, g, b} !== 24'h0) begin
                errs++;
                $display("FAIL black t=%0d got %h want 000000", t, {r, g, b});
            end
            if (t < 240 && pixel_de === 1'b1)
                de_cnt++;
        end
        vectors++;
        if (de_cnt != 96) begin
            errs++;
            $display("FAIL de_per_frame got %0d want 96", de_cnt);
        end
    endtask

    task automatic test_colour_bars();
        tim_t e;
        logic [23:0] want;
        do_reset(3'd3);
        for (int t = 0; t < 240; t++) begin
            @(negedge vga_clk);
            e    = model(t);
            want = e.de ? bar_rgb(e.x) : 24'h0;
            vectors++;
            if ({pixel_de, r, g, b} !== {e.de, want}) begin
                errs++;
                $display("FAIL bars t=%0d got %h want %h", t, {pixel_de, r, g, b}, {e.de, want});
            end
        end
    endtask

    task automatic test_mode_switch();
        tim_t e;
        logic [23:0] want;
        do_reset(3'd1);
        for (int t = 0; t < 480; t++) begin
            @(negedge vga_clk);
            e = model(t);
            if (!e.de)
                want = 24'h0;
            else if (t < 240)
                want = {3{e.x[7:0]}};
            else
                want = (e.x[1:0] == 2'd0 || e.y[1:0] == 2'd0) ? 24'hFFFFFF : 24'h0;
            vectors++;
            if ({r, g, b} !== want) begin
                errs++;
                $display("FAIL mode_switch t=%0d got %h want %h", t, {r, g, b}, want);
            end
            if (t == 100)
                mode = 3'd4;
        end
    endtask

    task automatic test_ext();
        tim_t e, nx;
        logic [23:0] want;
        do_reset(3'd5);
        ext_rgb = seed(0);
        for (int t = 0; t < 240; t++) begin
            @(negedge vga_clk);
            e    = model(t);
            nx   = model(t + 1);
            want = e.de ? seed(t) : 24'h0;
            vectors++;
            if ({pixel_de, r, g, b} !== {e.de, want}) begin
                errs++;
                $display("FAIL ext t=%0d got %h want %h", t, {pixel_de, r, g, b}, {e.de, want});
            end
            vectors++;
            if (pix_req !== nx.de) begin
                errs++;
                $display("FAIL ext_req t=%0d got %b want %b", t, pix_req, nx.de);
            end
            ext_rgb = seed(t + 1);
        end
    endtask

    task automatic test_en_drop();
        tim_t e, o;
        logic [7:0] fce;
        do_reset(3'd1);
        for (int t = 0; t < 30; t++)
            @(negedge vga_clk);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge vga_clk);
            o = obs();
            vectors++;
            if ({o, pix_req, r, g, b} !== '0) begin
                errs++;
                $display("FAIL en_low i=%0d got %h want 0", i, {o, pix_req, r, g, b});
            end
            vectors++;
            if (frame_cnt !== 8'd1) begin
                errs++;
                $display("FAIL en_low_fc i=%0d got %0d want 1", i, frame_cnt);
            end
        end
        en = 1'b1;
        for (int t = 0; t < 241; t++) begin
            @(negedge vga_clk);
            e   = model(t);
            o   = obs();
            fce = 8'(2 + t / 240);
            vectors++;
            if ({o, frame_cnt} !== {e, fce}) begin
                errs++;
                $display("FAIL en_resume t=%0d got %h want %h", t, {o, frame_cnt}, {e, fce});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        tim_t e, o;
        logic [7:0] fce;
        do_reset(3'd1);
        for (int t = 0; t <= 82; t++)
            @(negedge vga_clk);
        vectors++;
        if ({pixel_de, r, g, b} !== {1'b1, 24'h050505}) begin
            errs++;
            $display("FAIL pre_reset got %h want 1050505", {pixel_de, r, g, b});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pixel_de, r, g, b, pixel_x, frame_cnt, h_sync} !== '0) begin
            errs++;
            $display("FAIL async_reset got %h want 0",
                     {pixel_de, r, g, b, pixel_x, frame_cnt, h_sync});
        end
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int t = 0; t <= 97; t++)
            @(negedge vga_clk);
        vectors++;
        if ({p_h_sync, p_v_sync} !== 2'b01) begin
            errs++;
            $display("FAIL pre_reset_pol got %b want 01", {p_h_sync, p_v_sync});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({p_h_sync, p_v_sync, h_sync, p_fc} !== {3'b110, 8'd0}) begin
            errs++;
            $display("FAIL async_reset_pol got %h want %h",
                     {p_h_sync, p_v_sync, h_sync, p_fc}, {3'b110, 8'd0});
        end
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int t = 0; t < 245; t++) begin
            @(negedge vga_clk);
            e   = model(t);
            o   = obs();
            fce = 8'(1 + t / 240);
            vectors++;
            if ({o, frame_cnt} !== {e, fce}) begin
                errs++;
                $display("FAIL post_reset t=%0d got %h want %h", t, {o, frame_cnt}, {e, fce});
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_colour_bars();
        test_mode_switch();
        test_ext();
        test_en_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
